// File: rtl/line_rasterizer.sv
// line_rasterizer: draws one line segment per start request using integer
// Bresenham in all octants, emitting one pixel coordinate per accepted
// pixel_valid/pixel_ready handshake and pulsing done after the last pixel.
module line_rasterizer #(
   parameter int COORD_W = 11,
   parameter int ERR_W   = COORD_W + 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [COORD_W-1:0] x0,
   input  logic [COORD_W-1:0] y0,
   input  logic [COORD_W-1:0] x1,
   input  logic [COORD_W-1:0] y1,
   output logic               busy,
   output logic               pixel_valid,
   input  logic               pixel_ready,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      DRAW  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [COORD_W-1:0]      ONE_C  = COORD_W'(1);
   localparam logic signed [ERR_W-1:0] ZERO_E = '0;

   state_t state_q, state_d;

   // Latched endpoints
   logic [COORD_W-1:0] x0_q, x0_d;
   logic [COORD_W-1:0] y0_q, y0_d;
   logic [COORD_W-1:0] x1_q, x1_d;
   logic [COORD_W-1:0] y1_q, y1_d;

   // Current pixel position
   logic [COORD_W-1:0] x_q, x_d;
   logic [COORD_W-1:0] y_q, y_d;

   // Bresenham terms: dx >= 0, dy <= 0, err accumulates both
   logic signed [ERR_W-1:0] dx_q, dx_d;
   logic signed [ERR_W-1:0] dy_q, dy_d;
   logic signed [ERR_W-1:0] err_q, err_d;

   // Step directions: 1 means +1, 0 means -1
   logic sx_q, sx_d;
   logic sy_q, sy_d;

   // Setup arithmetic operands (endpoints zero-extended into signed ERR_W)
   logic signed [ERR_W-1:0] x0_s, x1_s, y0_s, y1_s;
   logic signed [ERR_W-1:0] dx_calc, dy_calc;

   // Per-pixel stepping terms
   logic signed [ERR_W-1:0] e2;
   logic signed [ERR_W-1:0] err_step;
   logic                    step_x, step_y, at_end;
   logic [COORD_W-1:0]      x_step, y_step;

   // Absolute deltas from the latched endpoints, used in the SETUP cycle
   always_comb begin
      x0_s    = signed'(ERR_W'(x0_q));
      x1_s    = signed'(ERR_W'(x1_q));
      y0_s    = signed'(ERR_W'(y0_q));
      y1_s    = signed'(ERR_W'(y1_q));
      dx_calc = (x1_s >= x0_s) ? (x1_s - x0_s) : (x0_s - x1_s);
      dy_calc = (y1_s >= y0_s) ? (y0_s - y1_s) : (y1_s - y0_s);
   end

   // One Bresenham step from the current pixel; both axes may step together
   always_comb begin
      e2       = err_q <<< 1;
      step_x   = (e2 >= dy_q);
      step_y   = (e2 <= dx_q);
      at_end   = (x_q == x1_q) && (y_q == y1_q);
      err_step = err_q + (step_x ? dy_q : ZERO_E) + (step_y ? dx_q : ZERO_E);
      x_step   = step_x ? (sx_q ? (x_q + ONE_C) : (x_q - ONE_C)) : x_q;
      y_step   = step_y ? (sy_q ? (y_q + ONE_C) : (y_q - ONE_C)) : y_q;
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      x0_d    = x0_q;
      y0_d    = y0_q;
      x1_d    = x1_q;
      y1_d    = y1_q;
      x_d     = x_q;
      y_d     = y_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      err_d   = err_q;
      sx_d    = sx_q;
      sy_d    = sy_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               x0_d    = x0;
               y0_d    = y0;
               x1_d    = x1;
               y1_d    = y1;
               state_d = SETUP;
            end
         end

         SETUP: begin
            dx_d    = dx_calc;
            dy_d    = dy_calc;
            sx_d    = (x0_q < x1_q);
            sy_d    = (y0_q < y1_q);
            err_d   = dx_calc + dy_calc;
            x_d     = x0_q;
            y_d     = y0_q;
            state_d = DRAW;
         end

         DRAW: begin
            // Position and error only advance on an accepted handshake;
            // stepping stops at the endpoint so x/y never wrap.
            if (pixel_ready) begin
               if (at_end) begin
                  state_d = DONE;
               end else begin
                  x_d   = x_step;
                  y_d   = y_step;
                  err_d = err_step;
               end
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         x0_q    <= '0;
         y0_q    <= '0;
         x1_q    <= '0;
         y1_q    <= '0;
         x_q     <= '0;
         y_q     <= '0;
         dx_q    <= '0;
         dy_q    <= '0;
         err_q   <= '0;
         sx_q    <= 1'b0;
         sy_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         x0_q    <= x0_d;
         y0_q    <= y0_d;
         x1_q    <= x1_d;
         y1_q    <= y1_d;
         x_q     <= x_d;
         y_q     <= y_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         err_q   <= err_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
      end
   end

   assign busy        = (state_q != IDLE);
   assign pixel_valid = (state_q == DRAW);
   assign done        = (state_q == DONE);
   assign x           = x_q;
   assign y           = y_q;

endmodule

// File: tb/tb_line_rasterizer.sv
// Scoreboard bench for line_rasterizer: directed lines push their expected
// pixels into a queue; a monitor pops and compares every accepted pixel.
module tb_line_rasterizer;

   localparam int COORD_W = 11;

   logic               clk = 1'b0;
   logic               reset;
   logic               start;
   logic [COORD_W-1:0] x0, y0, x1, y1;
   logic               busy;
   logic               pixel_valid;
   logic               pixel_ready;
   logic [COORD_W-1:0] x, y;
   logic               done;

   int n_cmp = 0;
   int n_bad = 0;

   logic [2*COORD_W-1:0] exp_q[$];

   line_rasterizer #(.COORD_W(COORD_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .x0          (x0),
      .y0          (y0),
      .x1          (x1),
      .y1          (y1),
      .busy        (busy),
      .pixel_valid (pixel_valid),
      .pixel_ready (pixel_ready),
      .x           (x),
      .y           (y),
      .done        (done)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push_pix(input int px, input int py);
      logic [COORD_W-1:0] ax, ay;
      ax = px[COORD_W-1:0];
      ay = py[COORD_W-1:0];
      exp_q.push_back({ax, ay});
   endtask

   // Monitor: every accepted pixel must match the head of the scoreboard
   always @(negedge clk) begin
      logic [2*COORD_W-1:0] e;
      if (pixel_valid === 1'b1 && pixel_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL extra_pixel: got (%0d,%0d) expected no pixel", x, y);
         end else begin
            e = exp_q.pop_front();
            chk("pix_x", 32'(x), 32'(e[2*COORD_W-1:COORD_W]));
            chk("pix_y", 32'(y), 32'(e[COORD_W-1:0]));
         end
      end
   end

   task automatic launch(input int a, input int b, input int c, input int d);
      @(posedge clk);
      #1;
      x0    = a[COORD_W-1:0];
      y0    = b[COORD_W-1:0];
      x1    = c[COORD_W-1:0];
      y1    = d[COORD_W-1:0];
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Waits (bounded) for done; exp_idx is the cycle index of done counted
   // from the end of launch (index 0 is the SETUP cycle).
   task automatic wait_done(input int exp_idx, input bit chk_launch, input int ex, input int ey);
      int  j    = 0;
      bit  seen = 1'b0;
      while (j < 3000 && !seen) begin
         @(negedge clk);
         if (chk_launch && j == 0) begin
            chk("setup_valid", 32'(pixel_valid), 0);
            chk("setup_busy", 32'(busy), 1);
         end
         if (chk_launch && j == 1) chk("first_valid_latency", 32'(pixel_valid), 1);
         if (done === 1'b1) seen = 1'b1;
         else j++;
      end
      if (!seen) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_timeout: got no done after %0d cycles expected done at %0d", j, exp_idx);
      end else begin
         chk("done_cycle", 32'(j), 32'(exp_idx));
         chk("done_busy", 32'(busy), 1);
         chk("done_valid", 32'(pixel_valid), 0);
         chk("pixels_left", 32'(exp_q.size()), 0);
         @(negedge clk);
         chk("done_one_cycle", 32'(done), 0);
         chk("idle_busy", 32'(busy), 0);
         chk("hold_x", 32'(x), 32'(ex));
         chk("hold_y", 32'(y), 32'(ey));
      end
   endtask

   task automatic push_shallow();
      push_pix(0, 0); push_pix(1, 0); push_pix(2, 1);
      push_pix(3, 1); push_pix(4, 2); push_pix(5, 2);
   endtask

   initial begin
      reset       = 1'b1;
      start       = 1'b0;
      pixel_ready = 1'b1;
      x0 = '0; y0 = '0; x1 = '0; y1 = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_valid", 32'(pixel_valid), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_x", 32'(x), 0);
      chk("rst_y", 32'(y), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Horizontal line: 321 pixels
      for (int k = 0; k <= 320; k++) push_pix(80 + k, 248);
      launch(80, 248, 400, 248);
      wait_done(322, 1'b1, 400, 248);

      // Vertical line, decreasing y: 427 pixels
      for (int k = 0; k <= 426; k++) push_pix(186, 532 - k);
      launch(186, 532, 186, 106);
      wait_done(428, 1'b1, 186, 106);

      // Shallow line
      push_shallow();
      launch(0, 0, 5, 2);
      wait_done(7, 1'b1, 5, 2);

      // Reversed diagonal
      for (int k = 0; k <= 10; k++) push_pix(10 - k, 10 - k);
      launch(10, 10, 0, 0);
      wait_done(12, 1'b1, 0, 0);

      // Backpressure at the third pixel plus an ignored mid-line start
      push_shallow();
      launch(0, 0, 5, 2);
      repeat (3) @(posedge clk);
      #1;
      pixel_ready = 1'b0;
      start       = 1'b1;
      x0 = 11'd7; y0 = 11'd7; x1 = 11'd7; y1 = 11'd7;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_valid", 32'(pixel_valid), 1);
         chk("stall_x", 32'(x), 2);
         chk("stall_y", 32'(y), 1);
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      pixel_ready = 1'b1;
      wait_done(4, 1'b0, 5, 2);

      // Degenerate point
      push_pix(7, 7);
      launch(7, 7, 7, 7);
      wait_done(2, 1'b1, 7, 7);

      // Reset at the 50th pixel of the horizontal line
      for (int k = 0; k < 50; k++) push_pix(80 + k, 248);
      launch(80, 248, 400, 248);
      repeat (50) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_valid", 32'(pixel_valid), 0);
      chk("abort_done", 32'(done), 0);
      chk("abort_x", 32'(x), 0);
      chk("abort_y", 32'(y), 0);
      chk("abort_pixels_left", 32'(exp_q.size()), 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort_no_done", 32'(done), 0);
      end

      // Fresh line after the abort
      push_shallow();
      launch(0, 0, 5, 2);
      wait_done(7, 1'b1, 5, 2);

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global time limit
   initial begin
      #1000000;
      $display("FAIL watchdog: got simulation timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/line_rasterizer.md
Name: line_rasterizer

Overview:
- Downstream stage of the tic-tac-toe screen sequencer: accepts one line segment (endpoints) per start request and emits the pixel coordinates of that segment, one per accepted handshake, using integer Bresenham for all octants.
- Output pixel stream feeds the VGA framebuffer write port, which may stall via pixel_ready.
- Signals done so the sequencer can advance to the next grid line or X/O stroke.

Parameters:
- COORD_W, 11, width of every x/y coordinate (unsigned).
- ERR_W, COORD_W+3, width of the signed internal error term; must not be overridden smaller.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to draw; sampled only in IDLE.
- x0  in  COORD_W  start point x; latched on accepted start.
- y0  in  COORD_W  start point y; latched on accepted start.
- x1  in  COORD_W  end point x; latched on accepted start.
- y1  in  COORD_W  end point y; latched on accepted start.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle inclusive.
- pixel_valid  out  1  x/y hold a pixel to write.
- pixel_ready  in  1  framebuffer accepts the pixel this cycle.
- x  out  COORD_W  current pixel x.
- y  out  COORD_W  current pixel y.
- done  out  1  one-cycle pulse after the last pixel is accepted.

Behaviour:
- Reset: state=IDLE; busy=0, pixel_valid=0, done=0, x=0, y=0; internal registers cleared. Reset mid-line aborts the line, emits no done, and takes effect on the next edge.
- States: IDLE -> SETUP -> DRAW -> DONE -> IDLE.
- IDLE: start=1 latches x0..y1 and goes to SETUP. start is ignored in every other state, including DONE; no queueing.
- SETUP (1 cycle):
  - dx=|x1-x0|, dy=-|y1-y0|.
  - sx=+1 if x0<x1, else -1; sy=+1 if y0<y1, else -1.
  - err=dx+dy. All arithmetic is signed ERR_W.
  - Load x=x0, y=y0.
- DRAW:
  - pixel_valid=1.
  - Latency: start sampled at cycle N gives the first pixel (x0,y0) valid at cycle N+2.
  - On pixel_valid && pixel_ready: if (x,y)==(x1,y1), go to DONE. Otherwise e2=2*err:
    - if e2>=dy: x+=sx, err+=dy.
    - if e2<=dx: y+=sy, err+=dx.
    - Both conditions apply in the same cycle when both hold; err accumulates both terms.
  - pixel_valid && !pixel_ready: x, y and err hold; pixel_valid stays 1. No pixel is skipped or repeated.
  - Throughput: one pixel per cycle while pixel_ready=1.
- Pixel count is exactly max(dx,|dy|)+1. The first pixel is (x0,y0) and the last is (x1,y1).
- DONE (1 cycle): done=1, pixel_valid=0, busy=1. Next state is IDLE.
- Degenerate point (x0==x1, y0==y1): exactly one pixel, then done.
- Endpoints span 0..2^COORD_W-1. There is no clipping, and x/y never wrap because stepping stops at the endpoint.
- x and y keep their last value while IDLE/DONE.

Test Plan:
- Horizontal line (80,248)->(400,248), pixel_ready=1 -> 321 pixels with x=80..400 and y=248 constant. First valid arrives 2 cycles after start; done pulses 1 cycle after pixel (400,248); busy=0 the following cycle.
- Vertical line (186,532)->(186,106), pixel_ready=1 -> 427 pixels with y=532 down to 106 and x=186.
- Shallow line (0,0)->(5,2) -> exact sequence (0,0),(1,0),(2,1),(3,1),(4,2),(5,2). Reversed line (10,10)->(0,0) -> 11 pixels (10-k,10-k).
- Backpressure on (0,0)->(5,2): hold pixel_ready=0 for 3 cycles at the third pixel -> (2,1) held stable with pixel_valid=1 for those cycles; the sequence is otherwise unchanged. Also pulse start mid-line -> ignored.
- Point line (7,7)->(7,7) -> exactly one pixel (7,7), then done. Reset asserted at the 50th pixel of the first line -> next cycle busy=0, pixel_valid=0, x=y=0, no done; a fresh start afterwards draws correctly.
